// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for four requesters sharing one result bus, plus the
// output register that holds the winning word under a valid/ready handshake.
module bus_arbiter4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  // Handshake: the word in `out` transfers to the consumer on a rising edge
  // where valid and ready are both high; valid never drops without a transfer.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             any;
  logic             accept;
  logic             load;
  logic [1:0]       eff_ptr;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             found;
  logic [WIDTH-1:0] mux_out;

  always_comb begin
    any     = |req;
    accept  = (state_q == FULL) & ready;
    load    = any & ((state_q == EMPTY) | accept);
    // The source being accepted this cycle drops to lowest priority at once.
    eff_ptr = accept ? (sel_q + 2'd1) : ptr_q;

    win   = eff_ptr;
    found = 1'b0;
    idx   = eff_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = eff_ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end

    case (win)
      2'd0:    mux_out = in0;
      2'd1:    mux_out = in1;
      2'd2:    mux_out = in2;
      default: mux_out = in3;
    endcase

    gnt = (load && rst_n) ? (4'b0001 << win) : 4'b0000;

    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    ptr_d   = accept ? (sel_q + 2'd1) : ptr_q;
    if (load) begin
      state_d = FULL;
      sel_d   = win;
      out_d   = mux_out;
    end else if (accept) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
    end
  end

  assign valid = (state_q == FULL);
  assign sel   = sel_q;
  assign out   = out_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: a requester/arbiter reference model
// predicts grants and pushes captured words; a monitor checks on acceptance.
module tb_bus_arbiter4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic         ready = 1'b0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] out;
  logic         valid;

  bus_arbiter4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .ready(ready), .gnt(gnt), .sel(sel), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] word[4];
  bit           pend[4];
  bit           m_valid = 0;
  int           m_sel = 0;
  int           m_ptr = 0;
  logic [3:0]   exp_gnt = 4'b0000;
  bit           exp_valid = 0;
  bit           mon_en = 0;

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: pick the first pending source scanning from the priority pointer.
  task automatic predict();
    int  eff, win;
    bit  any_r, acc, ld;
    any_r = (req != 4'b0000);
    acc   = m_valid && ready;
    ld    = any_r && (!m_valid || acc);
    eff   = acc ? (m_sel + 1) % 4 : m_ptr;
    win   = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && req[(eff + k) % 4]) win = (eff + k) % 4;
    exp_valid = m_valid;
    exp_gnt   = ld ? 4'(1 << win) : 4'b0000;
    if (acc) m_ptr = (m_sel + 1) % 4;
    if (ld) begin
      exp_q.push_back({2'(win), word[win]});
      m_sel     = win;
      m_valid   = 1;
      pend[win] = 0;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  // Called just after a rising edge; drives one cycle of inputs.
  task automatic step(input bit rdy);
    req   = {pend[3], pend[2], pend[1], pend[0]};
    in0   = pend[0] ? word[0] : $urandom;
    in1   = pend[1] ? word[1] : $urandom;
    in2   = pend[2] ? word[2] : $urandom;
    in3   = pend[3] ? word[3] : $urandom;
    ready = rdy;
    predict();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt", {30'd0, gnt}, {30'd0, exp_gnt});
      chk("valid", {33'd0, valid}, {33'd0, exp_valid});
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("accept_without_expected", 34'd1, 34'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("accepted_sel_out", {sel, out}, e);
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    m_valid = 0; m_sel = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
  endtask

  initial begin
    clear_model();
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {33'd0, valid}, 34'd0);
    chk("reset_out", {2'd0, out}, 34'd0);
    chk("reset_sel", {32'd0, sel}, 34'd0);
    chk("reset_gnt", {30'd0, gnt}, 34'd0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Single request, one-cycle latency, then idle.
    pend[2] = 1; word[2] = 32'hDEADBEEF;
    step(1);
    step(1);
    step(1);

    // All four held, full throughput.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) begin pend[i] = 1; word[i] = 32'h10 + i; end
      step(1);
    end
    for (int i = 0; i < 4; i++) pend[i] = 0;
    step(1);
    step(1);

    // Backpressure on a word from source 1 with 0 and 3 waiting, then wrap.
    pend[1] = 1; word[1] = $urandom;
    step(1);
    pend[0] = 1; word[0] = $urandom;
    pend[3] = 1; word[3] = $urandom;
    repeat (5) step(0);
    repeat (4) step(1);

    // Lone requester is never locked out.
    for (int c = 0; c < 6; c++) begin
      pend[0] = 1; word[0] = $urandom;
      step(1);
    end
    step(1);

    // Asynchronous reset while a word is held under backpressure.
    pend[0] = 1; word[0] = $urandom;
    pend[2] = 1; word[2] = $urandom;
    step(0);
    req = 4'b1111;
    ready = 1'b0;
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {33'd0, valid}, 34'd0);
    chk("midreset_out", {2'd0, out}, 34'd0);
    chk("midreset_gnt", {30'd0, gnt}, 34'd0);
    clear_model();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    pend[1] = 1; word[1] = $urandom;
    step(1);
    step(1);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          word[i] = $urandom;
        end
      step($urandom_range(0, 3) != 0);
    end

    // Drain with a bounded cycle budget.
    for (int c = 0; c < 20; c++) begin
      if (!(pend[0] || pend[1] || pend[2] || pend[3] || m_valid)) break;
      step(1);
    end
    step(1);
    chk("drained_queue", 34'(exp_q.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

- Round-robin arbiter and output register for one shared 32-bit result bus with four requesters.
- Each requester presents a word and a request. The block picks one winner and steers the shared 4:1 word mux (mux4) to it.
- The winning word is captured into an output register and held, under a valid/ready handshake, until the downstream consumer (register-file writeback or memory write port) accepts it.
- It is the sequencing and sharing control around the existing mux4 datapath.

## Interface
- WIDTH, 32, data width of requester words and of `out`
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per source; bit i belongs to in_i; held high until granted
- in0, in1, in2, in3  input  WIDTH  source words; must be stable while the matching req is high
- ready  input  1  consumer accepts `out` in this cycle when ready and valid are both high
- gnt  output  4  combinational one-hot grant; bit i high means in_i is captured at the next edge
- sel  output  2  registered index of the source currently held in `out`
- out  output  WIDTH  registered data word
- valid  output  1  `out` holds an unaccepted word

## Operation
- Internal signals:
  - `any` = |req.
  - `accept` = valid & ready.
  - `load` = any & (~valid | accept).
- Priority pointer `ptr` (2 bits) selects the first source searched.
- Winner search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Winner is the first source in that order whose req bit is high.
- Effective pointer in the current cycle:
  - When accept is high: (sel+1) mod 4, so the source just accepted becomes lowest priority.
  - Otherwise: the registered ptr.
- The winner index drives the mux4 select. The mux4 output is the D input of `out`.
- gnt = one-hot(winner) when load is high, else 4'b0000. gnt is 0 whenever rst_n is low.
- State is carried by `valid`:
  - EMPTY (valid=0):
    - load high → capture: `out` ← in_winner, `sel` ← winner, valid ← 1.
    - Otherwise stay EMPTY.
  - FULL (valid=1), ready low: hold out, sel and valid unchanged. gnt = 0. No source is captured.
  - FULL, ready high, any high: accept and capture the new winner in the same edge. valid stays 1.
  - FULL, ready high, any low: valid ← 0.
- ptr ← (sel+1) mod 4 on every accept edge. Otherwise ptr holds.
- A requester whose gnt is high must drop req, or present a new word, from the next cycle on. A req held high after its gnt is a new request.
- Reset values:
  - valid = 0, sel = 2'b00, out = 0, ptr = 2'b00.
  - gnt = 4'b0000 while rst_n is low.
- Reset asserted mid-operation discards the held word. No acceptance is reported after reset.

## Timing
- Request in cycle n with the block EMPTY: gnt high in cycle n, valid/out/sel updated at the edge ending cycle n. Latency is 1 cycle.
- Throughput is 1 word per cycle when ready is held high and any request is present.
- out, sel and valid change only at clock edges (or on reset). gnt depends combinationally on req, valid, ready and sel.
- ready is sampled only when valid is high. ready while EMPTY has no effect.
- Simultaneous accept and new requests: the pointer used is (sel+1) mod 4, not the registered ptr.
- rst_n deasserted: the first capture can happen at the first rising edge at which rst_n is high.

## Test plan
- Reset → valid=0, out=0, sel=0, gnt=0000. Then req=0100 with in2=0xDEADBEEF, ready=1 → gnt=0100 in the same cycle; next cycle valid=1, out=0xDEADBEEF, sel=2; the cycle after, valid=0.
- req=1111 held, ready=1, in_i = i+0x10 → accepted words in order 0x10, 0x11, 0x12, 0x13, 0x10, …, one per cycle, valid continuously high.
- Backpressure: word from in1 held with ready=0 for 5 cycles while req=1001 and in1 changes → out and sel stay constant, gnt=0000. Then ready=1 → next captured source is 3, then 0.
- Wrap-around: sel=3 accepted with req=1001 pending → source 0 wins (pointer wraps to 0) before source 3.
- Only one requester, req=0001 held with ready=1 → source 0 is granted every cycle (no lockout when alone); out follows in0 with one cycle of delay.
- rst_n pulled low asynchronously mid-cycle while valid=1 and ready=0 → valid=0, out=0 and gnt=0000 immediately. After release with req=0010 → source 1 is granted (ptr=0, and source 0 is not requesting).
